// File: rtl/if_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package if_pkg;

    localparam int unsigned DefAddrWidth     = 10;
    localparam int unsigned DefDataWidth     = 32;
    localparam int unsigned DefQueueDepth    = 2;
    localparam int unsigned DefTimeoutCycles = 16;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } fetch_state_e;

    typedef struct packed {
        logic [DefAddrWidth-1:0] addr;
        logic [DefDataWidth-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC control, instruction memory port and decode-side queue head.
interface instr_fetch_if
    import if_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth
) ();

    logic [ADDR_WIDTH-1:0] programCounter;
    logic                  flush;
    logic                  pcStall;
    logic                  memReq;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  memAck;
    logic [DATA_WIDTH-1:0] memData;
    logic                  instrValid;
    logic                  instrReady;
    logic [DATA_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0] instrPc;
    logic                  fetchError;

    modport master (
        input  programCounter, flush, memAck, memData, instrReady,
        output pcStall, memReq, memAddr, instrValid, instruction, instrPc, fetchError
    );

    modport slave (
        output programCounter, flush, memAck, memData, instrReady,
        input  pcStall, memReq, memAddr, instrValid, instruction, instrPc, fetchError
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched words; flush empties it and overrides push/pop.
module fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned WIDTH = DefAddrWidth + DefDataWidth,
    parameter int unsigned DEPTH = DefQueueDepth
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrWidth   = $clog2(DEPTH);
    localparam int unsigned CountWidth = PtrWidth + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountWidth-1:0] count_q;
    logic                  do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CountWidth'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty && !flush;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            if (do_push && !do_pop)      count_q <= count_q + CountWidth'(1);
            else if (!do_push && do_pop) count_q <= count_q - CountWidth'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one memory read per PC step and queues words for decode.
// Optional FETCH_TIMEOUT_EN adds an ack watchdog with a sticky fetchError.
module instr_fetch
    import if_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
    parameter int unsigned DATA_WIDTH     = DefDataWidth,
    parameter int unsigned QUEUE_DEPTH    = DefQueueDepth,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input logic           clock,
    input logic           resetN,
    instr_fetch_if.master bus
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    fetch_state_e          state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  push, pop, queue_full, queue_empty;
    logic                  timeout, fetch_error, pc_stall;
    entry_t                push_entry, head_entry;
    logic [$clog2(QUEUE_DEPTH):0] unused_queue_count;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoWidth-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                err_q;

    assign timeout = (state_q != StIdle) && !bus.memAck &&
                     (tmo_cnt_q == TmoWidth'(TIMEOUT_CYCLES - 1));
    assign fetch_error = err_q;

    // Counts cycles spent waiting on one outstanding request; any state change restarts it.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q != StIdle && state_d == state_q && !bus.memAck) begin
            tmo_cnt_d = tmo_cnt_q + TmoWidth'(1);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_q | timeout;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout     = 1'b0;
    assign fetch_error = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        pc_stall   = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (!bus.flush && !queue_full && !fetch_error) begin
                    state_d    = StReq;
                    mem_req_d  = 1'b1;
                    mem_addr_d = bus.programCounter;
                    pc_stall   = 1'b0;
                end
            end
            StReq: begin
                if (bus.memAck) begin
                    push      = !bus.flush;
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                end else if (bus.flush) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (bus.memAck) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (timeout) begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
        end
        // A taken branch always lets the PC load its target, unless the stage is dead or in reset.
        if (bus.flush) pc_stall = 1'b0;
        if (fetch_error || !resetN) pc_stall = 1'b1;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign push_entry = '{addr: mem_addr_q, data: bus.memData};
    assign pop        = !queue_empty && bus.instrReady;

    fetch_queue #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock     (clock),
        .resetN    (resetN),
        .push      (push),
        .pop       (pop),
        .flush     (bus.flush),
        .push_data (push_entry),
        .head_data (head_entry),
        .count     (unused_queue_count),
        .full      (queue_full),
        .empty     (queue_empty)
    );

    assign bus.pcStall     = pc_stall;
    assign bus.memReq      = mem_req_q;
    assign bus.memAddr     = mem_addr_q;
    assign bus.instrValid  = !queue_empty;
    assign bus.instruction = head_entry.data;
    assign bus.instrPc     = head_entry.addr;
    assign bus.fetchError  = fetch_error;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch plus directed scenarios for the corner cases.
module tb_instr_fetch;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic clock = 1'b0;
    logic resetN;
    always #5 clock = ~clock;

    instr_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    instr_fetch #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .QUEUE_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] pc_model, pc_reset_val, force_tgt;
    int unsigned   ack_max, ready_pct, flush_pct, slow_delay;
    int            slow_addr;
    bit            never_ack, ack_force, flush_force, mon_en;

    exp_t          exp_q[$];
    logic [AW-1:0] pop_log[$];
    int            issues = 0;
    int            pops   = 0;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return 32'hA5C3_0000 ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PC register and instruction memory living around the fetch stage.
    initial begin
        logic          st, fl;
        logic [AW-1:0] cur_tgt;
        bit            busy;
        int unsigned   wait_cnt, dly;
        bus.programCounter = '0;
        bus.flush          = 1'b0;
        bus.memAck         = 1'b0;
        bus.memData        = '0;
        bus.instrReady     = 1'b0;
        pc_model           = '0;
        cur_tgt            = '0;
        busy               = 1'b0;
        wait_cnt           = 0;
        dly                = 0;
        forever begin
            @(negedge clock);
            st = bus.pcStall;
            fl = bus.flush;
            @(posedge clock);
            #1;
            if (!resetN) pc_model = pc_reset_val;
            else if (!st) pc_model = fl ? cur_tgt : pc_model + AW'(1);
            bus.programCounter = pc_model;
            if (flush_force) begin
                bus.flush = 1'b1;
                cur_tgt   = force_tgt;
            end else if (resetN && $urandom_range(99) < flush_pct) begin
                bus.flush = 1'b1;
                cur_tgt   = AW'($urandom);
            end else begin
                bus.flush = 1'b0;
            end
            bus.instrReady = ($urandom_range(99) < ready_pct);
            bus.memAck     = 1'b0;
            bus.memData    = $urandom;
            if (ack_force) begin
                bus.memAck = 1'b1;
                busy       = 1'b0;
            end else if (bus.memReq && !never_ack) begin
                if (!busy) begin
                    busy     = 1'b1;
                    wait_cnt = 0;
                    dly = (int'(bus.memAddr) == slow_addr) ? slow_delay : $urandom_range(ack_max);
                end
                if (wait_cnt >= dly) begin
                    bus.memAck  = 1'b1;
                    bus.memData = mem_fn(bus.memAddr);
                    busy        = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Scoreboard: model the stage as "one outstanding read, FIFO of DEPTH, flush kills all".
    initial begin
        bit            outstanding, tainted, exp_stall;
        logic [AW-1:0] out_addr;
        exp_t          e;
        outstanding = 1'b0;
        tainted     = 1'b0;
        out_addr    = '0;
        forever begin
            @(negedge clock);
            if (!resetN) begin
                exp_q.delete();
                outstanding = 1'b0;
                tainted     = 1'b0;
            end else if (mon_en) begin
                exp_stall = bus.flush ? 1'b0 : !(!outstanding && exp_q.size() < DEPTH);
                check("pcStall", bus.pcStall, exp_stall);
                check("instrValid", bus.instrValid, exp_q.size() != 0);
                check("memReq", bus.memReq, outstanding);
                if (outstanding) check("memAddr", bus.memAddr, out_addr);
                check("fetchError", bus.fetchError, 0);
                if (bus.flush) begin
                    exp_q.delete();
                end else if (bus.instrValid && bus.instrReady && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("instrPc", bus.instrPc, e.addr);
                    check("instruction", bus.instruction, e.data);
                    pop_log.push_back(bus.instrPc);
                    pops++;
                end
                if (outstanding) begin
                    if (bus.flush) tainted = 1'b1;
                    if (bus.memAck) begin
                        if (!tainted) exp_q.push_back('{addr: out_addr, data: mem_fn(out_addr)});
                        outstanding = 1'b0;
                    end
                end else if (!exp_stall && !bus.flush) begin
                    outstanding = 1'b1;
                    tainted     = 1'b0;
                    out_addr    = pc_model;
                    issues++;
                end
            end
        end
    end

    task automatic do_reset(input logic [AW-1:0] pc);
        pc_reset_val = pc;
        resetN       = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        resetN = 1'b1;
    endtask

    function automatic logic [63:0] logged(input int idx);
        if (idx < pop_log.size()) return 64'(pop_log[idx]);
        return '1;
    endfunction

    initial begin
        int start, lows, cnt, hi, i0, p0;
        resetN       = 1'b0;
        mon_en       = 1'b0;
        ack_max      = 0;
        ready_pct    = 100;
        flush_pct    = 0;
        slow_addr    = -1;
        slow_delay   = 0;
        never_ack    = 1'b0;
        ack_force    = 1'b0;
        flush_force  = 1'b0;
        force_tgt    = '0;
        pc_reset_val = '0;

        repeat (2) @(posedge clock);
        #3;
        check("rst_memReq", bus.memReq, 0);
        check("rst_memAddr", bus.memAddr, 0);
        check("rst_instrValid", bus.instrValid, 0);
        check("rst_instruction", bus.instruction, 0);
        check("rst_instrPc", bus.instrPc, 0);
        check("rst_fetchError", bus.fetchError, 0);
        check("rst_pcStall", bus.pcStall, 1);
        mon_en = 1'b1;

        // Zero-wait memory, decode always ready: strict 1-in-2 issue rate.
        do_reset(0);
        start = pop_log.size();
        lows  = 0;
        repeat (8) begin
            @(negedge clock);
            if (!bus.pcStall) lows++;
        end
        check("zw_pcstall_lows", lows, 4);
        repeat (4) @(negedge clock);
        for (int i = 0; i < 4; i++) check("zw_order", logged(start + i), i);

        // Decode stalled: exactly two fetches fill the queue, then resume.
        ready_pct = 0;
        do_reset(5);
        i0 = issues;
        repeat (12) @(negedge clock);
        check("full_issues", issues - i0, 2);
        check("full_memReq", bus.memReq, 0);
        check("full_pcStall", bus.pcStall, 1);
        check("full_instrValid", bus.instrValid, 1);
        start     = pop_log.size();
        ready_pct = 100;
        repeat (10) @(negedge clock);
        for (int i = 0; i < 3; i++) check("full_resume", logged(start + i), 5 + i);

        // Slow ack: address held and PC stalled for the whole request.
        slow_addr  = 8;
        slow_delay = 2;
        do_reset(8);
        start = pop_log.size();
        cnt   = 0;
        hi    = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.memReq && bus.memAddr == AW'(8)) begin
                cnt++;
                if (bus.pcStall) hi++;
            end
        end
        check("slow_req_cycles", cnt, 3);
        check("slow_stall_cycles", hi, 3);
        repeat (4) @(negedge clock);
        check("slow_pc", logged(start), 8);
        slow_addr = -1;

        // Flush while address 12 is outstanding; next word comes from target 40.
        ready_pct  = 0;
        slow_addr  = 12;
        slow_delay = 2;
        do_reset(11);
        start = pop_log.size();
        repeat (2) @(posedge clock);
        #3;
        force_tgt   = 40;
        flush_force = 1'b1;
        @(posedge clock);
        #3;
        flush_force = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("flush_instrValid", bus.instrValid, 0);
        check("drop_memReq", bus.memReq, 1);
        check("drop_memAddr", bus.memAddr, 12);
        slow_addr = -1;
        ready_pct = 100;
        repeat (6) @(negedge clock);
        check("flush_target_pc", logged(start), 40);

        // Reset in the middle of a request, then a stray ack while idle.
        ready_pct  = 0;
        slow_addr  = 30;
        slow_delay = 5;
        do_reset(29);
        repeat (3) @(posedge clock);
        #2;
        check("midreq_memReq_pre", bus.memReq, 1);
        resetN       = 1'b0;
        ack_force    = 1'b1;
        pc_reset_val = 50;
        slow_addr    = -1;
        #1;
        check("midreq_memReq_rst", bus.memReq, 0);
        check("midreq_instrValid_rst", bus.instrValid, 0);
        @(posedge clock);
        #3;
        resetN    = 1'b1;
        ack_force = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("late_ack_nopush", bus.instrValid, 0);
        ready_pct = 100;

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: watchdog gives up after TIMEOUT_CYCLES and latches the error.
        mon_en    = 1'b0;
        never_ack = 1'b1;
        do_reset(60);
        cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.memReq) cnt++;
        end
        check("tmo_req_cycles", cnt, 16);
        check("tmo_fetchError", bus.fetchError, 1);
        check("tmo_memReq", bus.memReq, 0);
        repeat (3) begin
            @(negedge clock);
            check("tmo_pcStall", bus.pcStall, 1);
        end
        never_ack = 1'b0;
        mon_en    = 1'b1;
`endif

        // Random traffic: variable ack latency, decode back-pressure and branches.
        ack_max   = 3;
        ready_pct = 60;
        flush_pct = 6;
        p0        = pops;
        do_reset(AW'($urandom));
        repeat (2000) @(negedge clock);
        check("random_progress", (pops - p0) > 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
